threat_monitor: RTL and testbench
=================================

THREAT_MONITOR -- requirements
Module: threat_monitor

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset, sampled on the rising edge of clock.
REQ-002 Parameter YELLOW_TH, default 8'd96: lowest sensor score classified YELLOW.
REQ-003 Parameter RED_TH, default 8'd192: lowest sensor score classified RED; RED_TH > YELLOW_TH.
REQ-004 Parameter DEBOUNCE, default 3: consecutive valid samples of one class needed to change state; legal range 1..15.
REQ-005 Parameter RED_HOLD, default 16: minimum number of cycles RED stays asserted.
REQ-006 Parameter STALE_TO, default 32: number of idle cycles (sensor_valid low) that triggers the stale-data condition.
REQ-007 Parameter HYST, default 8'd8: hysteresis margin, used only when THREAT_MON_HYST_EN is defined.
REQ-008 Port clock, input, 1 bit: system clock.
REQ-009 Port reset_n, input, 1 bit: synchronous reset, active low.
REQ-010 Port sensor_valid, input, 1 bit: sensor_level holds a sample this cycle.
REQ-011 Port sensor_level, input, 8 bits: unsigned threat score.
REQ-012 Port green, output, 1 bit: level GREEN, drives the downstream green input.
REQ-013 Port yellow, output, 1 bit: level YELLOW, drives the downstream yellow input.
REQ-014 Port red, output, 1 bit: level RED, drives the downstream red input.
REQ-015 Port level, output, 2 bits: state code (IDLE=0, GREEN=1, YELLOW=2, RED=3).
REQ-016 Port red_events, output, 8 bits: count of entries into RED, saturating at 255.

Function
REQ-017 The block SHALL be a state machine with states IDLE, GREEN, YELLOW and RED; all outputs SHALL be registered.
REQ-018 green, yellow and red SHALL be one-hot in states GREEN, YELLOW and RED, and all zero in IDLE.
REQ-019 Each valid sample SHALL be classified as follows: score >= RED_TH gives RED; score >= YELLOW_TH gives YELLOW; any lower score gives GREEN.
REQ-020 A candidate register and a 4-bit stability counter SHALL track the class of consecutive valid samples; a valid sample of a different class SHALL reload the candidate and set the counter to 1.
REQ-021 When the counter reaches DEBOUNCE and the candidate differs from the current state, the state SHALL change on that same edge; outputs SHALL therefore be visible in the following cycle.
REQ-022 Cycles with sensor_valid low SHALL neither advance nor clear the stability counter.
REQ-023 Entering RED SHALL load a hold counter with RED_HOLD-1 and increment red_events; red_events SHALL saturate at 255.
REQ-024 While the hold counter is nonzero, exit from RED SHALL be blocked; a debounced exit request SHALL be retained and taken on the first cycle the hold counter is zero, provided the candidate is still stable.
REQ-025 Re-confirming RED while already in RED SHALL NOT reload the hold counter or increment red_events.
REQ-026 In GREEN, STALE_TO consecutive cycles without a valid sample SHALL force YELLOW; the stale counter SHALL clear on any valid sample.
REQ-027 When a valid sample and stale expiry fall on the same cycle, the sample SHALL win and the timeout SHALL NOT fire.
REQ-028 The stale timeout SHALL have no effect in IDLE, YELLOW or RED.
REQ-029 IDLE SHALL be left only through the first debounced class.

Reset
REQ-030 While reset_n is low at a clock edge, the block SHALL enter IDLE and clear green, yellow, red, level, red_events, and the candidate, stability, hold and stale counters; reset mid-hold SHALL abort the hold immediately.

Configuration
REQ-031 With THREAT_MON_HYST_EN defined, classification out of a higher current state SHALL use thresholds lowered by HYST: RED is left only below RED_TH-HYST, and YELLOW is left only below YELLOW_TH-HYST.
REQ-032 Without THREAT_MON_HYST_EN, classification SHALL use the plain thresholds, and HYST SHALL be unused.

Structure
REQ-033 Package threat_monitor_pkg SHALL hold the state enum, the level codes, and the default threshold, hold and timeout constants.
REQ-034 Sub-module threat_classifier SHALL hold the combinational score-to-class mapping, including hysteresis.
REQ-035 The state machine, debounce, hold and stale counters SHALL reside in threat_monitor.

Verification
REQ-036 Scenario: reset, then three valid samples of 50 -> level=1 and green=1 in the cycle after the third sample.
REQ-037 Scenario: in GREEN, samples 200, 200, 200 -> red=1 and red_events=1; then samples of 50 -> red stays high for 16 cycles total, then green=1.
REQ-038 Scenario: in GREEN, samples 100, 200, 100, 100, 100 -> no RED, and yellow=1 after the fifth sample.
REQ-039 Scenario: in GREEN, sensor_valid low for 32 cycles -> yellow=1; a variant with a valid sample of 50 on cycle 32 -> stays GREEN.
REQ-040 Scenario: THREAT_MON_HYST_EN defined, in RED after hold, three samples of 190 -> stays RED; three samples of 180 -> YELLOW.
REQ-041 Scenario: reset_n low for one cycle during RED hold -> level=0 and red_events=0 the next cycle.

Source files
------------

// File: rtl/threat_monitor_pkg.sv
// ============================================================================
// Module   : threat_monitor_pkg
// Purpose  : State encoding, level codes and default constants for the
//            threat monitor.
// Revision : 1.0
// ============================================================================
`default_nettype none

package threat_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2,
        ST_RED    = 2'd3
    } state_t;

    localparam logic [1:0] c_LVL_IDLE   = 2'd0;
    localparam logic [1:0] c_LVL_GREEN  = 2'd1;
    localparam logic [1:0] c_LVL_YELLOW = 2'd2;
    localparam logic [1:0] c_LVL_RED    = 2'd3;

    localparam logic [7:0] c_YELLOW_TH_DEF = 8'd96;
    localparam logic [7:0] c_RED_TH_DEF    = 8'd192;
    localparam int         c_DEBOUNCE_DEF  = 3;
    localparam int         c_RED_HOLD_DEF  = 16;
    localparam int         c_STALE_TO_DEF  = 32;
    localparam logic [7:0] c_HYST_DEF      = 8'd8;

endpackage

`default_nettype wire

// File: rtl/threat_classifier.sv
// ============================================================================
// Module   : threat_classifier
// Purpose  : Combinational score-to-class mapping. Hysteresis is compiled in
//            when THREAT_MON_HYST_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module threat_classifier
    import threat_monitor_pkg::*;
#(
    parameter logic [7:0] YELLOW_TH = c_YELLOW_TH_DEF,
    parameter logic [7:0] RED_TH    = c_RED_TH_DEF,
    parameter logic [7:0] HYST      = c_HYST_DEF
) (
    input  logic [7:0] i_score,
    input  state_t     i_state,
    output state_t     o_cls
);

    logic [7:0] w_red_th;
    logic [7:0] w_yel_th;

`ifdef THREAT_MON_HYST_EN
    // Leaving a higher state requires the score to drop below the lowered threshold.
    always_comb begin
        w_red_th = RED_TH;
        w_yel_th = YELLOW_TH;
        if (i_state == ST_RED) begin
            w_red_th = RED_TH - HYST;
        end
        if (i_state == ST_RED || i_state == ST_YELLOW) begin
            w_yel_th = YELLOW_TH - HYST;
        end
    end
`else
    logic w_unused_hyst;
    assign w_unused_hyst = ^{i_state, HYST};
    assign w_red_th      = RED_TH;
    assign w_yel_th      = YELLOW_TH;
`endif

    always_comb begin
        o_cls = ST_GREEN;
        if (i_score >= w_red_th) begin
            o_cls = ST_RED;
        end else if (i_score >= w_yel_th) begin
            o_cls = ST_YELLOW;
        end
    end

endmodule

`default_nettype wire

// File: rtl/threat_monitor.sv
// ============================================================================
// Module   : threat_monitor
// Purpose  : Debounced GREEN/YELLOW/RED threat state machine with RED hold,
//            stale-data timeout and saturating RED entry counter.
//            Optional hysteresis: define THREAT_MON_HYST_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module threat_monitor
    import threat_monitor_pkg::*;
#(
    parameter logic [7:0] YELLOW_TH = c_YELLOW_TH_DEF,
    parameter logic [7:0] RED_TH    = c_RED_TH_DEF,
    parameter int         DEBOUNCE  = c_DEBOUNCE_DEF,
    parameter int         RED_HOLD  = c_RED_HOLD_DEF,
    parameter int         STALE_TO  = c_STALE_TO_DEF,
    parameter logic [7:0] HYST      = c_HYST_DEF
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       sensor_valid,
    input  logic [7:0] sensor_level,
    output logic       green,
    output logic       yellow,
    output logic       red,
    output logic [1:0] level,
    output logic [7:0] red_events
);

    localparam int                c_HOLD_W    = (RED_HOLD > 1) ? $clog2(RED_HOLD) : 1;
    localparam int                c_STALE_W   = $clog2(STALE_TO + 1);
    localparam logic [c_HOLD_W-1:0]  c_HOLD_LOAD = c_HOLD_W'(RED_HOLD - 1);
    localparam logic [c_STALE_W-1:0] c_STALE_MAX = c_STALE_W'(STALE_TO);
    localparam logic [3:0]        c_DEB       = 4'(DEBOUNCE);

    state_t               r_state, w_state_nx;
    state_t               r_cand,  w_cand_nx;
    state_t               w_cls;
    logic [3:0]           r_stab,  w_stab_nx;
    logic [c_HOLD_W-1:0]  r_hold,  w_hold_nx;
    logic [c_STALE_W-1:0] r_stale, w_stale_nx;
    logic                 r_pend,  w_pend_nx;
    logic [7:0]           r_events, w_events_nx;
    logic                 w_stable;
    logic                 w_req;
    logic                 r_green, r_yellow, r_red;
    logic [1:0]           r_level;

    threat_classifier #(
        .YELLOW_TH (YELLOW_TH),
        .RED_TH    (RED_TH),
        .HYST      (HYST)
    ) u_classifier (
        .i_score (sensor_level),
        .i_state (r_state),
        .o_cls   (w_cls)
    );

    always_comb begin
        w_state_nx  = r_state;
        w_cand_nx   = r_cand;
        w_stab_nx   = r_stab;
        w_hold_nx   = r_hold;
        w_stale_nx  = r_stale;
        w_pend_nx   = 1'b0;
        w_events_nx = r_events;

        if (sensor_valid) begin
            if (w_cls != r_cand) begin
                w_cand_nx = w_cls;
                w_stab_nx = 4'd1;
            end else if (r_stab != 4'hF) begin
                w_stab_nx = r_stab + 4'd1;
            end
        end

        // A pending request survives idle cycles as long as the candidate stays stable.
        w_stable = (w_stab_nx >= c_DEB) && (w_cand_nx != r_state);
        w_req    = w_stable && (sensor_valid || r_pend);

        if (r_hold != '0) begin
            w_hold_nx = r_hold - 1'b1;
        end

        if (w_req) begin
            if (r_state == ST_RED && r_hold != '0) begin
                w_pend_nx = 1'b1;
            end else begin
                w_state_nx = w_cand_nx;
            end
        end

        if (r_state != ST_GREEN || sensor_valid) begin
            w_stale_nx = '0;
        end else if (c_STALE_W'(r_stale + 1'b1) == c_STALE_MAX) begin
            w_stale_nx = '0;
            w_state_nx = ST_YELLOW;
        end else begin
            w_stale_nx = r_stale + 1'b1;
        end

        if (w_state_nx == ST_RED && r_state != ST_RED) begin
            w_hold_nx = c_HOLD_LOAD;
            if (r_events != 8'hFF) begin
                w_events_nx = r_events + 8'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_cand   <= ST_IDLE;
            r_stab   <= '0;
            r_hold   <= '0;
            r_stale  <= '0;
            r_pend   <= 1'b0;
            r_events <= '0;
            r_green  <= 1'b0;
            r_yellow <= 1'b0;
            r_red    <= 1'b0;
            r_level  <= c_LVL_IDLE;
        end else begin
            r_state  <= w_state_nx;
            r_cand   <= w_cand_nx;
            r_stab   <= w_stab_nx;
            r_hold   <= w_hold_nx;
            r_stale  <= w_stale_nx;
            r_pend   <= w_pend_nx;
            r_events <= w_events_nx;
            r_green  <= (w_state_nx == ST_GREEN);
            r_yellow <= (w_state_nx == ST_YELLOW);
            r_red    <= (w_state_nx == ST_RED);
            r_level  <= w_state_nx;
        end
    end

    assign green      = r_green;
    assign yellow     = r_yellow;
    assign red        = r_red;
    assign level      = r_level;
    assign red_events = r_events;

endmodule

`default_nettype wire

// File: tb/tb_threat_monitor.sv
// ============================================================================
// Module   : tb_threat_monitor
// Purpose  : Directed self-checking bench for threat_monitor; expectations
//            follow THREAT_MON_HYST_EN where hysteresis changes the outcome.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_threat_monitor;

`ifdef THREAT_MON_HYST_EN
    localparam bit c_HYST = 1'b1;
`else
    localparam bit c_HYST = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       sensor_valid = 1'b0;
    logic [7:0] sensor_level = 8'd0;
    logic       green, yellow, red;
    logic [1:0] level;
    logic [7:0] red_events;

    int n_vec  = 0;
    int n_fail = 0;

    threat_monitor dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .sensor_valid (sensor_valid),
        .sensor_level (sensor_level),
        .green        (green),
        .yellow       (yellow),
        .red          (red),
        .level        (level),
        .red_events   (red_events)
    );

    always #5 clock = ~clock;

    task automatic tick(input logic v, input logic [7:0] l);
        sensor_valid = v;
        sensor_level = l;
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n, input logic v, input logic [7:0] l);
        for (int i = 0; i < n; i++) tick(v, l);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Checks level code and the one-hot lamp outputs together.
    task automatic chk_state(input string tag, input logic [1:0] exp_lvl);
        logic [4:0] obs;
        logic [4:0] exp;
        obs = {green, yellow, red, level};
        exp = {exp_lvl == 2'd1, exp_lvl == 2'd2, exp_lvl == 2'd3, exp_lvl};
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed gyr/level %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        reset_n = 1'b0;
        ticks(2, 1'b0, 8'd0);
        chk_state("reset_state", 2'd0);
        chk("reset_events", red_events, 8'd0);
        reset_n = 1'b1;

        // First debounced class leaves IDLE
        ticks(2, 1'b1, 8'd50);
        chk_state("idle_2_samples", 2'd0);
        tick(1'b1, 8'd50);
        chk_state("idle_to_green", 2'd1);

        // Enter RED, then hold for 16 cycles total
        ticks(2, 1'b1, 8'd200);
        chk_state("green_2_red_samples", 2'd1);
        tick(1'b1, 8'd200);
        chk_state("enter_red", 2'd3);
        chk("red_events_1", red_events, 8'd1);
        for (int i = 0; i < 15; i++) begin
            tick(1'b1, 8'd50);
            chk("red_hold", {7'd0, red}, 8'd1);
        end
        tick(1'b1, 8'd50);
        chk_state("red_hold_exit", 2'd1);

        // Interrupted run never reaches RED
        tick(1'b1, 8'd100);
        tick(1'b1, 8'd200);
        ticks(2, 1'b1, 8'd100);
        chk_state("mixed_4th", 2'd1);
        tick(1'b1, 8'd100);
        chk_state("mixed_to_yellow", 2'd2);
        chk("mixed_no_red_event", red_events, 8'd1);
        ticks(2, 1'b1, 8'd50);
        chk_state("yellow_2_green_samples", 2'd2);
        tick(1'b1, 8'd50);
        chk_state("yellow_to_green", 2'd1);

        // Stale timeout
        ticks(31, 1'b0, 8'd0);
        chk_state("stale_31", 2'd1);
        tick(1'b0, 8'd0);
        chk_state("stale_32", 2'd2);
        tick(1'b1, 8'd50);
        chk_state("stale_recover", 2'd1);
        ticks(31, 1'b0, 8'd0);
        tick(1'b1, 8'd50);
        chk_state("stale_sample_wins", 2'd1);
        ticks(31, 1'b0, 8'd0);
        chk_state("stale_cleared", 2'd1);
        tick(1'b0, 8'd0);
        chk_state("stale_again", 2'd2);
        tick(1'b1, 8'd50);
        chk_state("stale_recover2", 2'd1);

        // RED, reconfirm through hold, then hysteresis behaviour
        ticks(3, 1'b1, 8'd200);
        chk_state("red_again", 2'd3);
        ticks(15, 1'b1, 8'd200);
        chk("reconfirm_no_count", red_events, 8'd2);
        chk_state("reconfirm_stay_red", 2'd3);
        ticks(2, 1'b1, 8'd190);
        chk_state("s190_2", 2'd3);
        tick(1'b1, 8'd190);
        chk_state("s190_3", c_HYST ? 2'd3 : 2'd2);
        ticks(3, 1'b1, 8'd180);
        chk_state("s180_3", 2'd2);

        // Reset in the middle of a RED hold
        ticks(3, 1'b1, 8'd200);
        chk("red_events_3", red_events, 8'd3);
        tick(1'b1, 8'd200);
        reset_n = 1'b0;
        tick(1'b0, 8'd0);
        chk_state("reset_mid_hold", 2'd0);
        chk("reset_mid_hold_events", red_events, 8'd0);
        reset_n = 1'b1;

        // Threshold boundaries
        ticks(3, 1'b1, 8'd96);
        chk_state("boundary_96", 2'd2);
        ticks(3, 1'b1, 8'd95);
        chk_state("boundary_95", c_HYST ? 2'd2 : 2'd1);
        ticks(3, 1'b1, 8'd191);
        chk_state("boundary_191", 2'd2);
        ticks(3, 1'b1, 8'd192);
        chk_state("boundary_192", 2'd3);
        chk("events_after_reset", red_events, 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
